// File: rtl/col_seq_ctrl_if.sv
// rtl/col_seq_ctrl_if.sv - request/response handshake bundle for col_seq_ctrl
//
// Ports (signals):
//   req_valid  requester -> controller  request present
//   req_ready  controller -> requester  controller idle and able to accept
//   req_op     requester -> controller  00 WRITE, 01 RD_WL, 10 RD_WLB, 11 reserved
//   req_addr   requester -> controller  target row
//   req_wdata  requester -> controller  write data bit
//   rsp_valid  controller -> requester  one-cycle response pulse
//   rsp_rdata  controller -> requester  read result, held until next response
//   rsp_err    controller -> requester  reserved-op flag, held until next response

interface col_seq_ctrl_if #(
   parameter int ADDR_W = 2
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic              req_wdata;
   logic              rsp_valid;
   logic              rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/col_seq_ctrl.sv
// rtl/col_seq_ctrl.sv - phase sequencer for one SRAM column (precharge, access, response)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   bus        slave modport of col_seq_ctrl_if (request/response handshake)
//   sa_out     in   sense-amp output from the column
//   preb       out  precharge, active low
//   w_en       out  write driver enable
//   write_bit  out  write driver data
//   SAE        out  sense-amp enable
//   WL         out  wordlines, one-hot or zero
//   WLB        out  complementary wordlines, one-hot or zero

module col_seq_ctrl #(
   parameter  int ADDR_W  = 2,
   parameter  int PRE_CYC = 1,
   parameter  int ACC_CYC = 1,
   localparam int ROWS    = 1 << ADDR_W
) (
   input  logic            clk,
   input  logic            rst_n,
   col_seq_ctrl_if.slave   bus,
   input  logic            sa_out,
   output logic            preb,
   output logic            w_en,
   output logic            write_bit,
   output logic            SAE,
   output logic [ROWS-1:0] WL,
   output logic [ROWS-1:0] WLB
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PRE  = 2'd1;
   localparam logic [1:0] ACC  = 2'd2;
   localparam logic [1:0] RSP  = 2'd3;

   localparam logic [1:0] OP_WRITE  = 2'b00;
   localparam logic [1:0] OP_RD_WL  = 2'b01;
   localparam logic [1:0] OP_RD_WLB = 2'b10;
   localparam logic [1:0] OP_RSV    = 2'b11;

   // Counter holds "cycles remaining minus one" for the current phase.
   localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
   localparam logic [3:0] ACC_LOAD = 4'(ACC_CYC - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [1:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ROWS-1:0]   row_sel;

   logic ready_q;
   logic rsp_valid_q;
   logic rsp_rdata_q;
   logic rsp_err_q;

   assign row_sel       = ROWS'(1) << addr_q;

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

   // Every output is a register set on the edge that enters the state it
   // belongs to, so the drive pattern lines up exactly with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         op_q        <= OP_WRITE;
         addr_q      <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         preb        <= 1'b0;
         w_en        <= 1'b0;
         write_bit   <= 1'b0;
         SAE         <= 1'b0;
         WL          <= '0;
         WLB         <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               // ready rises one cycle after reset release and stays up
               // until a request is taken.
               ready_q <= 1'b1;
               if (bus.req_valid && ready_q) begin
                  ready_q <= 1'b0;
                  op_q    <= bus.req_op;
                  addr_q  <= bus.req_addr;
                  if (bus.req_op == OP_RSV) begin
                     // Reserved op: answer immediately, array untouched.
                     state       <= RSP;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 1'b0;
                  end else begin
                     state <= PRE;
                     cnt   <= PRE_LOAD;
                     if (bus.req_op == OP_WRITE) begin
                        write_bit <= bus.req_wdata;
                     end
                  end
               end
            end

            PRE: begin
               if (cnt == 4'd0) begin
                  state <= ACC;
                  cnt   <= ACC_LOAD;
                  preb  <= 1'b1;
                  // WRITE drives both rails of the selected row; a read
                  // opens only the rail it senses through.
                  w_en  <= (op_q == OP_WRITE);
                  SAE   <= (op_q != OP_WRITE);
                  WL    <= (op_q != OP_RD_WLB) ? row_sel : '0;
                  WLB   <= (op_q != OP_RD_WL)  ? row_sel : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            ACC: begin
               if (cnt == 4'd0) begin
                  state       <= RSP;
                  preb        <= 1'b0;
                  w_en        <= 1'b0;
                  SAE         <= 1'b0;
                  WL          <= '0;
                  WLB         <= '0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  // Sensing through WLB sees the complement, so invert to
                  // return the stored bit on both read paths.
                  case (op_q)
                     OP_RD_WL:  rsp_rdata_q <= sa_out;
                     OP_RD_WLB: rsp_rdata_q <= ~sa_out;
                     default:   rsp_rdata_q <= 1'b0;
                  endcase
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            RSP: begin
               state   <= IDLE;
               ready_q <= 1'b1;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/col_seq_ctrl.md
# col_seq_ctrl

Sequencer for one SRAM column, covering its precharge, write-enable, sense-amp enable and WL/WLB row drivers. It accepts single-bit write and read requests over a valid/ready handshake. For each request it generates the precharge → access → response phase sequence, then returns read data sampled from the column sense amplifier. It sits between the array access logic and the column datapath, and replaces hand-driven per-phase stimulus.

## Interface
Parameters:
- ADDR_W, default 2: row address width; ROWS = 2**ADDR_W wordlines.
- PRE_CYC, default 1: precharge cycles per access; legal range 1..15.
- ACC_CYC, default 1: access (WL/WLB asserted) cycles per access; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; high only in IDLE.
- req_op  in  2  00 WRITE, 01 RD_WL, 10 RD_WLB, 11 reserved.
- req_addr  in  ADDR_W  target row.
- req_wdata  in  1  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  1  read result; valid with rsp_valid.
- rsp_err  out  1  reserved op flag; valid with rsp_valid.
- sa_out  in  1  sense-amp output from column.
- preb  out  1  precharge, active low (0 = precharging).
- w_en  out  1  write driver enable.
- write_bit  out  1  write driver data.
- SAE  out  1  sense-amp enable.
- WL  out  ROWS  wordlines, one-hot or zero.
- WLB  out  ROWS  complementary wordlines, one-hot or zero.

## Operation
- All outputs are registered.
- Reset values: preb=0, w_en=0, write_bit=0, SAE=0, WL=0, WLB=0, req_ready=0 during reset and 1 in the first cycle after release, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states are IDLE, PRE, ACC and RSP.
- IDLE:
  - preb=0, all WL/WLB/w_en/SAE=0, req_ready=1.
  - req_valid&&req_ready accepts the request. Op, addr and wdata are latched.
  - WRITE also loads write_bit from wdata. write_bit holds its value otherwise, including across reads.
- PRE: preb=0 for exactly PRE_CYC cycles, then ACC.
- ACC: preb=1 for exactly ACC_CYC cycles. Row drive depends on op:
  - WRITE: WL[addr]=WLB[addr]=1, w_en=1, SAE=0.
  - RD_WL: WL[addr]=1, WLB=0, SAE=1, w_en=0.
  - RD_WLB: WLB[addr]=1, WL=0, SAE=1, w_en=0.
- Read sampling: sa_out is sampled on the clock edge that ends the last ACC cycle.
  - RD_WL: rsp_rdata = sa_out.
  - RD_WLB: rsp_rdata = ~sa_out, so both read paths return the stored bit.
  - WRITE: rsp_rdata = 0.
- RSP: preb=0, WL/WLB/w_en/SAE=0, rsp_valid=1 for one cycle, then IDLE.
- rsp_rdata and rsp_err hold their values until the next rsp_valid.
- Reserved op (11): goes IDLE→RSP directly, with no PRE or ACC. rsp_err=1, rsp_rdata=0, no array activity, write_bit unchanged.
- Invariants:
  - preb=1 only in ACC.
  - SAE and w_en are never high together.
  - At most one WL bit and one WLB bit are high.
  - WL/WLB are never high while preb=0.
- Phase counter is 4 bits. It loads at state entry and counts down to 0. No wrap is possible within the legal parameter range.
- Reset mid-operation: all outputs return to reset values immediately (asynchronously). Any in-flight request is dropped with no response.

## Timing
- Accept at edge T: PRE occupies cycles T+1..T+PRE_CYC.
- ACC occupies the next ACC_CYC cycles.
- rsp_valid is high in cycle T+PRE_CYC+ACC_CYC+1.
- req_ready is high again in the following cycle.
- Minimum request spacing is PRE_CYC+ACC_CYC+2 cycles. Reserved op spacing is 2 cycles.
- req_valid held high with req_ready low is ignored, and the request fields are not sampled.
- The request must stay stable only in the accept cycle.

## Test plan
- Reset: assert rst_n=0 mid-ACC of a WRITE → preb=0, WL=WLB=0, w_en=0, SAE=0 immediately; no rsp_valid after release; req_ready=1 in the first cycle after release.
- WRITE addr=0, wdata=0 (defaults 1/1) → one PRE cycle with preb=0, then one cycle with preb=1, WL=WLB=4'b0001, w_en=1, write_bit=0; rsp_valid the next cycle with rsp_err=0.
- RD_WL addr=1 with sa_out=1 during ACC → WL=4'b0010, WLB=0, SAE=1, rsp_rdata=1. Repeat with RD_WLB and sa_out=1 → WLB=4'b0010, rsp_rdata=0.
- WRITE wdata=1 then RD_WL, with req_valid held high → write_bit remains 1 through the read; second accept occurs exactly 4 cycles after the first; no overlap of w_en and SAE.
- req_op=11 → rsp_valid one cycle after accept, rsp_err=1, preb never 1, write_bit unchanged.
- PRE_CYC=3, ACC_CYC=2 → preb low 3 cycles then high 2 cycles; rsp_valid at T+6; sa_out change before the final ACC edge is reflected in rsp_rdata.
